// File: rtl/banco_pkg.sv
// Shared types and defaults for the parameterised register bank.
// Holds the clear-FSM state type and default geometry constants.
package banco_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/banco_rd_port.sv
// Combinational read port: array mux, write bypass, zero-register forcing.
// Ports: addr, rows (flattened array), byp_en/byp_addr/byp_data, data.
module banco_rd_port #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic [AW-1:0]          addr,
  input  logic [DEPTH*WIDTH-1:0] rows,
  input  logic                   byp_en,
  input  logic [AW-1:0]          byp_addr,
  input  logic [WIDTH-1:0]       byp_data,
  output logic [WIDTH-1:0]       data
);

  always_comb begin
    data = rows[int'(addr)*WIDTH +: WIDTH];
    if (byp_en && (byp_addr == addr)) begin
      data = byp_data;
    end
    // Hard-wired zero wins over any bypass.
    if ((ZERO_REG != 0) && (addr == '0)) begin
      data = '0;
    end
  end

endmodule

// File: rtl/banco_registros_param.sv
// Parameterised 2R1W register bank with write bypass and a sequential clear.
// Ports: clk, rst (sync high), we/DE/Dato write, DL1/DL2 -> op1/op2 reads,
//        clr start-clear, listo (writes accepted), err_we (sticky write-in-clear).
module banco_registros_param
  import banco_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    DE,
  input  logic [WIDTH-1:0] Dato,
  input  logic [AW-1:0]    DL1,
  input  logic [AW-1:0]    DL2,
  input  logic             clr,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic             listo,
  output logic             err_we
);

  logic [WIDTH-1:0] br_q [DEPTH];
  logic [WIDTH-1:0] br_d [DEPTH];
  clr_state_e       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             err_we_q, err_we_d;

  logic             byp_en;
  logic             wr_ok;
  logic [DEPTH*WIDTH-1:0] rows;

  assign listo  = (state_q == IDLE);
  assign err_we = err_we_q;

  // Bypass only when the write will really commit; the read
  // port itself masks address 0 in zero-register mode.
  assign byp_en = we && listo;
  assign wr_ok  = byp_en &&
                  !((ZERO_REG != 0) && (DE == '0));

  always_comb begin
    br_d     = br_q;
    state_d  = state_q;
    idx_d    = idx_q;
    err_we_d = err_we_q;
    unique case (state_q)
      IDLE: begin
        if (wr_ok) begin
          br_d[DE] = Dato;
        end
        if (clr) begin
          state_d  = CLEAR;
          idx_d    = '0;
          err_we_d = 1'b0;
        end
      end
      CLEAR: begin
        br_d[idx_q] = '0;
        idx_d       = idx_q + 1'b1;
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
        if (we) begin
          err_we_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_q     <= '{default: '0};
      state_q  <= IDLE;
      idx_q    <= '0;
      err_we_q <= 1'b0;
    end else begin
      br_q     <= br_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      err_we_q <= err_we_d;
    end
  end

  always_comb begin
    rows = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rows[i*WIDTH +: WIDTH] = br_q[i];
    end
  end

  banco_rd_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_rd1 (
    .addr     (DL1),
    .rows     (rows),
    .byp_en   (byp_en),
    .byp_addr (DE),
    .byp_data (Dato),
    .data     (op1)
  );

  banco_rd_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_rd2 (
    .addr     (DL2),
    .rows     (rows),
    .byp_en   (byp_en),
    .byp_addr (DE),
    .byp_data (Dato),
    .data     (op2)
  );

endmodule

// File: tb/tb_banco_registros_param.sv
// Self-checking bench for banco_registros_param (default and small config).
// Expected values come from a bench-side memory model through a queue.
module tb_banco_registros_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        we = 1'b0;
  logic [4:0]  de = '0;
  logic [31:0] dato = '0;
  logic [4:0]  dl1 = '0;
  logic [4:0]  dl2 = '0;
  logic        clr = 1'b0;
  logic [31:0] op1, op2;
  logic        listo, err_we;

  logic        we_s = 1'b0;
  logic [1:0]  de_s = '0;
  logic [7:0]  dato_s = '0;
  logic [1:0]  dl1_s = '0;
  logic [1:0]  dl2_s = '0;
  logic        clr_s = 1'b0;
  logic [7:0]  op1_s, op2_s;
  logic        listo_s, err_s;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem [32];
  logic [31:0] exp_q [$];
  logic [31:0] e;
  int          cnt;

  always #5 clk = ~clk;

  banco_registros_param dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .DE     (de),
    .Dato   (dato),
    .DL1    (dl1),
    .DL2    (dl2),
    .clr    (clr),
    .op1    (op1),
    .op2    (op2),
    .listo  (listo),
    .err_we (err_we)
  );

  banco_registros_param #(
    .WIDTH    (8),
    .DEPTH    (4),
    .ZERO_REG (0)
  ) dut_s (
    .clk    (clk),
    .rst    (rst),
    .we     (we_s),
    .DE     (de_s),
    .Dato   (dato_s),
    .DL1    (dl1_s),
    .DL2    (dl2_s),
    .clr    (clr_s),
    .op1    (op1_s),
    .op2    (op2_s),
    .listo  (listo_s),
    .err_we (err_s)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; de = a; dato = d;
    tick();
    we = 1'b0;
    if (a != 0) mem[a] = d;
  endtask

  task automatic test_reset;
    we = 1'b1; de = 5'd3; dato = 32'h55; clr = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; we = 1'b0; clr = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    #1;
    n_vec++;
    if (listo !== 1'b1) begin
      n_err++; $display("FAIL reset_listo got %b want 1", listo);
    end
    n_vec++;
    if (err_we !== 1'b0) begin
      n_err++; $display("FAIL reset_err got %b want 0", err_we);
    end
    for (int i = 0; i < 32; i++) begin
      dl1 = 5'(i); dl2 = 5'(31 - i);
      exp_q.push_back(mem[i]);
      exp_q.push_back(mem[31 - i]);
      #1;
      e = exp_q.pop_front(); n_vec++;
      if (op1 !== e) begin
        n_err++; $display("FAIL reset_op1[%0d] got %h want %h", i, op1, e);
      end
      e = exp_q.pop_front(); n_vec++;
      if (op2 !== e) begin
        n_err++; $display("FAIL reset_op2[%0d] got %h want %h", 31 - i, op2, e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      dl1_s = 2'(i);
      #1;
      n_vec++;
      if (op1_s !== 8'h00) begin
        n_err++; $display("FAIL reset_small[%0d] got %h want 00", i, op1_s);
      end
    end
  endtask

  task automatic test_write_read;
    dl1 = 5'd1;
    wr(5'd5, 32'hDEADBEEF);
    dl1 = 5'd5;
    exp_q.push_back(mem[5]);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (op1 !== e) begin
      n_err++; $display("FAIL wr_rd op1 got %h want %h", op1, e);
    end
    dl2 = 5'd4;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (op2 !== e) begin
      n_err++; $display("FAIL wr_rd_neighbor op2 got %h want %h", op2, e);
    end
  endtask

  task automatic test_bypass_zero;
    we = 1'b1; de = 5'd7; dato = 32'h12345678;
    dl1 = 5'd7; dl2 = 5'd7;
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'h12345678);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (op1 !== e) begin
      n_err++; $display("FAIL byp_op1 got %h want %h", op1, e);
    end
    e = exp_q.pop_front(); n_vec++;
    if (op2 !== e) begin
      n_err++; $display("FAIL byp_op2 got %h want %h", op2, e);
    end
    tick();
    we = 1'b0;
    mem[7] = 32'h12345678;
    exp_q.push_back(mem[7]);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (op1 !== e) begin
      n_err++; $display("FAIL byp_stored got %h want %h", op1, e);
    end
    we = 1'b1; de = 5'd0; dato = 32'hFFFFFFFF;
    dl1 = 5'd0; dl2 = 5'd5;
    exp_q.push_back(32'h0);
    exp_q.push_back(mem[5]);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (op1 !== e) begin
      n_err++; $display("FAIL zero_byp op1 got %h want %h", op1, e);
    end
    e = exp_q.pop_front(); n_vec++;
    if (op2 !== e) begin
      n_err++; $display("FAIL zero_other op2 got %h want %h", op2, e);
    end
    tick();
    we = 1'b0;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (op1 !== e) begin
      n_err++; $display("FAIL zero_stored op1 got %h want %h", op1, e);
    end
  endtask

  task automatic test_clear;
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    dl1 = 5'd17;
    exp_q.push_back(mem[17]);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (op1 !== e) begin
      n_err++; $display("FAIL fill_r17 got %h want %h", op1, e);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cnt = 0;
    while (!listo && cnt < 100) begin
      cnt++;
      tick();
    end
    for (int i = 0; i < 32; i++) mem[i] = '0;
    n_vec++;
    if (cnt !== 32) begin
      n_err++; $display("FAIL clear_len got %0d want 32", cnt);
    end
    for (int i = 0; i < 32; i++) begin
      dl1 = 5'(i); dl2 = 5'(i);
      exp_q.push_back(mem[i]);
      #1;
      e = exp_q.pop_front(); n_vec++;
      if (op1 !== e || op2 !== e) begin
        n_err++;
        $display("FAIL clear_rd[%0d] got %h/%h want %h", i, op1, op2, e);
      end
    end
  endtask

  task automatic test_err_clear;
    wr(5'd1, 32'h22);
    wr(5'd31, 32'h11);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    mem[0] = '0; mem[1] = '0;
    we = 1'b1; de = 5'd31; dato = 32'hA5A5A5A5;
    dl1 = 5'd31; dl2 = 5'd1;
    exp_q.push_back(mem[31]);
    exp_q.push_back(mem[1]);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (op1 !== e) begin
      n_err++; $display("FAIL err_nobyp op1 got %h want %h", op1, e);
    end
    e = exp_q.pop_front(); n_vec++;
    if (op2 !== e) begin
      n_err++; $display("FAIL err_partial op2 got %h want %h", op2, e);
    end
    n_vec++;
    if (listo !== 1'b0) begin
      n_err++; $display("FAIL err_listo got %b want 0", listo);
    end
    tick();
    we = 1'b0;
    n_vec++;
    if (err_we !== 1'b1) begin
      n_err++; $display("FAIL err_set got %b want 1", err_we);
    end
    cnt = 0;
    while (!listo && cnt < 100) begin
      cnt++;
      tick();
    end
    for (int i = 0; i < 32; i++) mem[i] = '0;
    n_vec++;
    if (listo !== 1'b1) begin
      n_err++; $display("FAIL err_timeout listo got %b want 1", listo);
    end
    n_vec++;
    if (err_we !== 1'b1) begin
      n_err++; $display("FAIL err_hold got %b want 1", err_we);
    end
    dl1 = 5'd31;
    exp_q.push_back(mem[31]);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (op1 !== e) begin
      n_err++; $display("FAIL err_r31 got %h want %h", op1, e);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_vec++;
    if (err_we !== 1'b0) begin
      n_err++; $display("FAIL err_clr got %b want 0", err_we);
    end
    cnt = 0;
    while (!listo && cnt < 100) begin
      cnt++;
      tick();
    end
    n_vec++;
    if (cnt !== 32) begin
      n_err++; $display("FAIL err_clear2_len got %0d want 32", cnt);
    end
  endtask

  task automatic test_reset_mid_clear;
    wr(5'd3, 32'h33);
    wr(5'd20, 32'h2020);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    we = 1'b1; de = 5'd20; dato = 32'h1;
    tick();
    we = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    n_vec++;
    if (listo !== 1'b1) begin
      n_err++; $display("FAIL rmc_listo got %b want 1", listo);
    end
    n_vec++;
    if (err_we !== 1'b0) begin
      n_err++; $display("FAIL rmc_err got %b want 0", err_we);
    end
    for (int i = 0; i < 32; i++) begin
      dl1 = 5'(i); dl2 = 5'(31 - i);
      exp_q.push_back(mem[i]);
      exp_q.push_back(mem[31 - i]);
      #1;
      e = exp_q.pop_front(); n_vec++;
      if (op1 !== e) begin
        n_err++; $display("FAIL rmc_op1[%0d] got %h want %h", i, op1, e);
      end
      e = exp_q.pop_front(); n_vec++;
      if (op2 !== e) begin
        n_err++; $display("FAIL rmc_op2[%0d] got %h want %h", 31 - i, op2, e);
      end
    end
    tick();
    n_vec++;
    if (listo !== 1'b1) begin
      n_err++; $display("FAIL rmc_idle got %b want 1", listo);
    end
  endtask

  task automatic test_params;
    we_s = 1'b1; de_s = 2'd0; dato_s = 8'h3C;
    dl1_s = 2'd0; dl2_s = 2'd0;
    exp_q.push_back(32'h3C);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (op1_s !== e[7:0]) begin
      n_err++; $display("FAIL par_byp0 got %h want %h", op1_s, e[7:0]);
    end
    tick();
    we_s = 1'b0;
    exp_q.push_back(32'h3C);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (op1_s !== e[7:0] || op2_s !== e[7:0]) begin
      n_err++;
      $display("FAIL par_r0 got %h/%h want %h", op1_s, op2_s, e[7:0]);
    end
    clr_s = 1'b1;
    tick();
    clr_s = 1'b0;
    cnt = 0;
    while (!listo_s && cnt < 100) begin
      cnt++;
      tick();
    end
    n_vec++;
    if (cnt !== 4) begin
      n_err++; $display("FAIL par_clear_len got %0d want 4", cnt);
    end
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); n_vec++;
    if (op1_s !== e[7:0]) begin
      n_err++; $display("FAIL par_cleared got %h want %h", op1_s, e[7:0]);
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_write_read();
    test_bypass_zero();
    test_clear();
    test_err_clear();
    test_reset_mid_clear();
    test_params();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
